// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding and
// default parameter values used by the scheduler and its bench.
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } sched_state_t;

  localparam int unsigned DEF_N_REQ        = 4;
  localparam int unsigned DEF_ID_W         = 2;
  localparam int unsigned DEF_BUSY_TIMEOUT = 64;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after i_ptr (modulo N_REQ) and returns it one-hot and encoded.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_valid
);

  int unsigned w_best;
  int unsigned w_best_dist;
  int unsigned w_dist;

  // Distance from the pointer decides priority, so the scan never needs a
  // variable bit index into the request vector.
  always_comb begin
    w_best      = 0;
    w_best_dist = N_REQ;
    w_dist      = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (i_req[k]) begin
        w_dist = (k + N_REQ - 32'(i_ptr)) % N_REQ;
        if (w_dist < w_best_dist) begin
          w_best_dist = w_dist;
          w_best      = k;
        end
      end
    end
  end

  always_comb begin
    o_grant = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      o_grant[k] = (w_best_dist != N_REQ) && (w_best == k);
    end
  end

  assign o_valid = (w_best_dist != N_REQ);
  assign o_idx   = ID_W'(w_best);

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte sources:
// accept one byte, pulse shoot, then follow tx busy through the whole frame.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned N_REQ        = DEF_N_REQ,
  parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  parameter int unsigned ID_W         = DEF_ID_W
) (
  input  logic               clk_i,
  input  logic               resetn_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [7:0]         tx_data_o,
  output logic               tx_shoot_o,
  input  logic               tx_busy_i,
  output logic [ID_W-1:0]    grant_id_o,
  output logic               timeout_o
);

  localparam int unsigned TMR_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [7:0]       r_tx_data;
  logic             r_shoot;
  logic [ID_W-1:0]  r_grant_id;
  logic             r_timeout;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_nxt;
  logic             w_timeout_nxt;
  logic             w_shoot_nxt;

  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_idx;
  logic             w_any;
  logic             w_accept;
  logic [7:0]       w_data;
  logic [ID_W-1:0]  w_ptr_nxt;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .i_req   (req_valid_i),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_any)
  );

  // Ready is held low while reset is asserted even though the state reads IDLE.
  assign w_accept    = resetn_i && (r_state == ST_IDLE) && !tx_busy_i && w_any;
  assign req_ready_o = w_accept ? w_grant : '0;

  always_comb begin
    w_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_idx == ID_W'(k)) begin
        w_data = req_data_i[8*k +: 8];
      end
    end
  end

  assign w_ptr_nxt = (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + ID_W'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_timeout_nxt = 1'b0;
    w_shoot_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_WAIT_BUSY;
          w_timer_nxt = '0;
          w_shoot_nxt = 1'b1;
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy_i) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_timer == TMR_LAST) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_timeout <= 1'b0;
      r_shoot   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_timeout <= w_timeout_nxt;
      r_shoot   <= w_shoot_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_rr_ptr   <= '0;
      r_tx_data  <= '0;
      r_grant_id <= '0;
    end else if (w_accept) begin
      r_rr_ptr   <= w_ptr_nxt;
      r_tx_data  <= w_data;
      r_grant_id <= w_idx;
    end
  end

  assign tx_data_o  = r_tx_data;
  assign tx_shoot_o = r_shoot;
  assign grant_id_o = r_grant_id;
  assign timeout_o  = r_timeout;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: the transmitter busy line is modelled from shoot
// timestamps; a timestamp-based reference predicts every output each cycle.
module tb_uart_tx_sched;

  localparam int N   = 4;
  localparam int T   = 24;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           resetn;
  logic [N-1:0]   v;
  logic [8*N-1:0] dat_bus;
  logic [N-1:0]   rdy;
  logic [7:0]     txd;
  logic           shoot;
  logic           tx_busy;
  logic [IDW-1:0] gid;
  logic           tout;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .N_REQ        (N),
    .BUSY_TIMEOUT (T),
    .ID_W         (IDW)
  ) dut (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .req_valid_i (v),
    .req_data_i  (dat_bus),
    .req_ready_o (rdy),
    .tx_data_o   (txd),
    .tx_shoot_o  (shoot),
    .tx_busy_i   (tx_busy),
    .grant_id_o  (gid),
    .timeout_o   (tout)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference state: timestamps (cycle numbers) rather than an FSM.
  int         m_ptr = 0;
  int         m_gid = 0;
  logic [7:0] m_data = '0;
  int         m_shoot = -1;
  int         m_to = -1;
  int         m_rise = -1;
  int         m_fall = -1;
  int         m_free = 0;
  bit         pend_acc = 0;
  int         pend_win = 0;
  logic [7:0] pend_data = '0;

  bit         stuck_next = 0;
  bit         rand_mode = 0;
  bit         force_busy = 0;
  int         stale_cnt = 0;
  int         len_min = 2;
  int         len_max = 10;
  logic [N-1:0] v_set = '0;

  int         obs_gid[$];
  logic [7:0] obs_data[$];
  int         obs_shoot_cyc = -1;
  int         obs_to_cyc = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] vv, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (vv[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic eval_cycle();
    int w;
    logic [N-1:0] er;
    @(negedge clk);
    w  = -1;
    er = '0;
    if (cyc >= m_free && !tx_busy) begin
      w = rr_pick(v, m_ptr);
      if (w >= 0) er[w] = 1'b1;
    end
    check_eq("ready", 32'(rdy), 32'(er));
    check_eq("shoot", 32'(shoot), 32'(cyc == m_shoot));
    check_eq("data", 32'(txd), 32'(m_data));
    check_eq("grant_id", 32'(gid), 32'(m_gid));
    check_eq("timeout", 32'(tout), 32'(cyc == m_to));
    if (shoot) begin
      obs_gid.push_back(int'(gid));
      obs_data.push_back(txd);
      obs_shoot_cyc = cyc;
    end
    if (tout) obs_to_cyc = cyc;
    pend_acc = |(er & v);
    if (pend_acc) begin
      pend_win  = w;
      pend_data = dat_bus[8*w +: 8];
    end
  endtask

  task automatic step();
    bit st;
    @(posedge clk);
    cyc++;
    #1;
    if (pend_acc) begin
      m_data  = pend_data;
      m_gid   = pend_win;
      m_ptr   = (pend_win + 1) % N;
      m_shoot = cyc;
      v[pend_win] = 1'b0;
      st = stuck_next || (rand_mode && $urandom_range(0, 7) == 0);
      stuck_next = 0;
      if (st) begin
        m_rise = -1;
        m_fall = -1;
        m_to   = cyc + T;
        m_free = cyc + T;
      end else begin
        m_rise = cyc + $urandom_range(1, 3);
        m_fall = m_rise + $urandom_range(len_min, len_max);
        m_free = m_fall + 1;
        m_to   = -1;
      end
      pend_acc = 0;
    end
    v = v | v_set;
    v_set = '0;
    if (rand_mode) begin
      for (int k = 0; k < N; k++) begin
        if (v[k]) begin
          if ($urandom_range(0, 99) < 8) v[k] = 1'b0;
        end else if ($urandom_range(0, 99) < 25) begin
          v[k] = 1'b1;
          dat_bus[8*k +: 8] = 8'($urandom);
        end
      end
      if (stale_cnt > 0) stale_cnt--;
      else if (cyc >= m_free && $urandom_range(0, 29) == 0) stale_cnt = $urandom_range(1, 4);
    end else begin
      stale_cnt = 0;
    end
    tx_busy = (cyc >= m_rise && cyc < m_fall) || (stale_cnt > 0) || force_busy;
    eval_cycle();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    bit expired;
    n = 0;
    do begin
      step();
      n++;
    end while (!(cyc >= m_free && v == '0 && v_set == '0 && !pend_acc) && n < budget);
    expired = !(cyc >= m_free && v == '0 && v_set == '0 && !pend_acc);
    check_eq("wait_idle_budget", 32'(expired), 32'd0);
  endtask

  task automatic reset_model();
    m_ptr = 0; m_gid = 0; m_data = '0;
    m_shoot = -1; m_to = -1; m_rise = -1; m_fall = -1; m_free = 0;
    pend_acc = 0; stale_cnt = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ready"}, 32'(rdy), 32'd0);
    check_eq({tag, "_shoot"}, 32'(shoot), 32'd0);
    check_eq({tag, "_data"}, 32'(txd), 32'd0);
    check_eq({tag, "_gid"}, 32'(gid), 32'd0);
    check_eq({tag, "_timeout"}, 32'(tout), 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    cyc++;
    #1;
    resetn  = 1'b1;
    tx_busy = 1'b0;
    eval_cycle();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    resetn  = 1'b0;
    tx_busy = 1'b0;
    v       = '1;
    dat_bus = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    v = '0;
    reset_model();
    release_reset();

    // All four requesters at once, pointer at 0.
    dat_bus = {8'h44, 8'h33, 8'h22, 8'h11};
    v_set = 4'b1111;
    obs_gid.delete(); obs_data.delete();
    run_until_idle(400);
    check_eq("all4_count", 32'(obs_gid.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("all4_gid", 32'(obs_gid[i]), 32'(i));
      check_eq("all4_data", 32'(obs_data[i]), 32'(8'h11 * (i + 1)));
    end

    // Single request from requester 0.
    dat_bus[7:0] = 8'h4F;
    v_set = 4'b0001;
    obs_gid.delete(); obs_data.delete();
    run_until_idle(200);
    check_eq("single_count", 32'(obs_gid.size()), 32'd1);
    check_eq("single_gid", 32'(obs_gid[0]), 32'd0);
    check_eq("single_data", 32'(obs_data[0]), 32'h4F);

    // Move the pointer to 2, then offer requesters 0 and 3.
    v_set = 4'b0010;
    run_until_idle(200);
    v_set = 4'b1001;
    obs_gid.delete(); obs_data.delete();
    run_until_idle(400);
    check_eq("rr_count", 32'(obs_gid.size()), 32'd2);
    check_eq("rr_first", 32'(obs_gid[0]), 32'd3);
    check_eq("rr_second", 32'(obs_gid[1]), 32'd0);

    // External busy while idle holds off the grant.
    force_busy = 1;
    v_set = 4'b0010;
    repeat (6) step();
    check_eq("busy_hold_ready", 32'(rdy), 32'd0);
    force_busy = 0;
    step();
    check_eq("busy_drop_ready", 32'(rdy), 32'b0010);
    run_until_idle(200);

    // Busy never rises: timeout pulse, then the next request is served.
    stuck_next = 1;
    v_set = 4'b0001;
    obs_to_cyc = -1;
    run_until_idle(200);
    check_eq("timeout_delay", 32'(obs_to_cyc - obs_shoot_cyc), 32'(T));
    v_set = 4'b0100;
    obs_gid.delete(); obs_data.delete();
    run_until_idle(200);
    check_eq("after_to_count", 32'(obs_gid.size()), 32'd1);
    check_eq("after_to_gid", 32'(obs_gid[0]), 32'd2);

    // Reset in the middle of a long frame.
    len_min = 20; len_max = 20;
    dat_bus[23:16] = 8'hA5;
    v_set = 4'b0100;
    n = 0;
    do begin step(); n++; end while (!tx_busy && n < 30);
    check_eq("midframe_busy_seen", 32'(tx_busy), 32'd1);
    repeat (3) step();
    v = 4'b0110;
    #2;
    resetn  = 1'b0;
    tx_busy = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    reset_model();
    repeat (2) begin @(posedge clk); cyc++; end
    len_min = 2; len_max = 10;
    obs_gid.delete(); obs_data.delete();
    release_reset();
    run_until_idle(400);
    check_eq("post_reset_count", 32'(obs_gid.size()), 32'd2);
    check_eq("post_reset_first", 32'(obs_gid[0]), 32'd1);
    check_eq("post_reset_second", 32'(obs_gid[1]), 32'd2);

    // Randomised traffic with stale busy and stuck frames.
    rand_mode = 1;
    repeat (3000) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one uart_tx_op transmitter among N_REQ byte sources.
- Each source offers a byte over a valid/ready handshake.
- The scheduler picks a winner, latches its byte and issues a single-cycle shoot to uart_tx_op.
- It then tracks uart_busy through a full frame before granting again.
- It sits between the application byte producers and uart_tx_op, which is clocked by the same clk plus a clk_divider enable.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 64, clk cycles to wait for tx_busy_i to rise after a shoot before declaring a fault.
- ID_W, 2, width of grant_id_o; must satisfy 2**ID_W >= N_REQ.

Ports:
- clk_i  in  1  system clock.
- resetn_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  N_REQ  requester k has a byte pending.
- req_data_i  in  8*N_REQ  byte of requester k at bits [8k+7:8k].
- req_ready_o  out  N_REQ  one-hot accept; the transfer occurs when valid and ready are both high on a clk edge.
- tx_data_o  out  8  byte to uart_tx_op datain_i.
- tx_shoot_o  out  1  start pulse to uart_tx_op shoot_i.
- tx_busy_i  in  1  from uart_tx_op uart_busy_o.
- grant_id_o  out  ID_W  index of the requester currently being served.
- timeout_o  out  1  one-cycle pulse when the busy-rise timeout fires.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, tx_data_o=0, tx_shoot_o=0, grant_id_o=0, timeout_o=0, timer=0. req_ready_o=0 combinationally, because state is not IDLE-eligible during reset.
- States: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE, winner selection:
  - Winner = first k with req_valid_i[k]=1, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - req_ready_o = onehot(winner) only when state=IDLE, tx_busy_i=0 and at least one valid; otherwise all zero.
  - req_ready_o is combinational from state, tx_busy_i and req_valid_i. It never depends on req_ready_o itself.
- IDLE, on accept (edge with valid&ready):
  - tx_data_o <= req_data_i[winner]; grant_id_o <= winner; tx_shoot_o <= 1.
  - rr_ptr <= (winner+1) mod N_REQ; timer <= 0; state <= WAIT_BUSY.
- tx_shoot_o is high for exactly one clk cycle, the cycle after accept. tx_data_o is stable from that cycle until the next accept.
- WAIT_BUSY:
  - If tx_busy_i=1: state <= WAIT_DONE.
  - Else timer increments. When timer reaches BUSY_TIMEOUT-1 with tx_busy_i still 0: timeout_o pulses 1 cycle, state <= IDLE, and the byte is dropped (no retry).
- WAIT_DONE: when tx_busy_i=0, state <= IDLE. There is no timeout here, because frame length is set by the divider.
- Accept-to-shoot latency is 1 cycle. Minimum gap between accepts = 1 (shoot) + busy-rise delay + frame length + 1 (IDLE) cycles.
- A requester dropping valid without ready has no effect (no lock). Data is sampled only on the accept edge.
- tx_busy_i high while in IDLE (external/stale busy) holds off all grants.
- Simultaneous valids are resolved only by rr_ptr; fixed priority is never used.
- If only one requester is active, it is served back-to-back, with rr_ptr moving past it each time.
- Reset asserted mid-frame returns every output to its reset value immediately. uart_tx_op is reset by the same resetn_i.

Decomposition:
- Shared package/header holds:
  - State encodings: IDLE=2'd0, WAIT_BUSY=2'd1, WAIT_DONE=2'd2.
  - Default BUSY_TIMEOUT.
- One natural sub-module: rr_arbiter (inputs req vector and pointer, output one-hot grant and encoded index; combinational, parameterised by N_REQ). It is reusable for other shared peripherals.
- The FSM, timer and data register stay in uart_tx_sched.

Test Plan:
- Bench setup: uart_tx_sched with uart_tx_op (parity on, even) and clk_divider DIVISOR=7; 10 ns clk.
- Single request: req0 valid with 0x4F after reset -> ready[0] one cycle, tx_shoot_o 1 cycle later with tx_data_o=0x4F, grant_id_o=0; uart_tx_o frame decodes 0x4F with even parity; state back to IDLE after busy falls.
- All four valid simultaneously (0x11,0x22,0x33,0x44) and held -> grants in order 0,1,2,3, one per frame; no ready while tx_busy_i=1; wire carries 0x11,0x22,0x33,0x44.
- rr_ptr=2 with req0 and req3 valid -> req3 granted first, then req0.
- Busy stuck low (uart_tx_op replaced by a tie-off) -> timeout_o pulses exactly BUSY_TIMEOUT cycles after the shoot, FSM returns to IDLE, the next request is accepted.
- resetn_i pulled low mid-frame during WAIT_DONE -> all outputs 0 asynchronously; after release, the first grant goes to the lowest valid index starting from 0.
- tx_busy_i forced high while IDLE with req1 valid -> req_ready_o stays 0 until busy drops, then ready[1] in the same cycle.
